gcd_apb_regbank: RTL
====================

GCD_APB_REGBANK -- requirements
Module: gcd_apb_regbank

Interface
REQ-001 Parameter NUM_CH, default 2, number of GCD channels, legal 1..4.
REQ-002 Parameter OPCODE_W, default 12, per-channel opcode width, legal 1..16.
REQ-003 Parameter CNT_W, default 12, cycle-count width, legal 1..32.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESETn  input  1  asynchronous active-low reset.
REQ-006 PADDR  input  32  APB address; only PADDR[7:2] decoded.
REQ-007 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-008 PWDATA  input  32  APB write data.
REQ-009 PRDATA  output  32  APB read data.
REQ-010 PREADY  output  1  tied 1.
REQ-011 PSLVERR  output  1  error response for unmapped access or rejected start.
REQ-012 START_PULSE  output  NUM_CH  one-cycle start per channel.
REQ-013 OPCODE  output  NUM_CH*OPCODE_W  channel c at [c*OPCODE_W +: OPCODE_W].
REQ-014 CONSTANT_TIME, DEBUG_MODE  output  NUM_CH each  per-channel mode bits.
REQ-015 DONE_PULSE  input  NUM_CH  one-cycle completion per channel.
REQ-016 CYCLE_COUNT  input  NUM_CH*CNT_W  live per-channel count.
REQ-017 DEBUG_IN  input  NUM_CH*32  per-channel debug word.
REQ-018 IRQ  output  1  aggregated interrupt.

Function
REQ-019 Map: 0x00 ID, read-only 0x5A5A_0000 | NUM_CH; 0x04 IRQ_STAT, W1C, bits [NUM_CH-1:0]; 0x08 IRQ_EN, RW, bits [NUM_CH-1:0]; channel c base B=0x10+0x10*c: B+0 CTRL, B+4 STATUS, B+8 CNT_LATCH, B+C DEBUG.
REQ-020 CTRL: [0] START (write-only, reads 0), [1 +: OPCODE_W] OPCODE, [17] DEBUG_MODE, [18] CONSTANT_TIME; other bits read 0.
REQ-021 STATUS: [0] RUN, [1] ERR (sticky), [2] DONE_SEEN (sticky); W1C on bits [2:1]; RUN read-only.
REQ-022 Setup phase = PSEL & ~PENABLE; writes, W1C and read-data capture happen on the setup-phase edge; PRDATA and PSLVERR hold registered values through the access phase.
REQ-023 Unmapped offset (including channel index >= NUM_CH): write ignored, PRDATA=0, PSLVERR=1 in access phase.
REQ-024 Write to CTRL with PWDATA[0]=1 while RUN=0: START_PULSE[c]=1 for exactly the next cycle, RUN sets the cycle after the pulse; OPCODE/mode fields update at the same edge as the write.
REQ-025 Write to CTRL with PWDATA[0]=1 while RUN=1: no pulse, OPCODE/mode fields unchanged, ERR sets, PSLVERR=1 in access phase.
REQ-026 DONE_PULSE[c]: RUN clears, DONE_SEEN sets, IRQ_STAT[c] sets, CNT_LATCH captures CYCLE_COUNT[c] zero-extended to 32 bits, all on the same edge.
REQ-027 DONE_PULSE[c] and a W1C of the same bit on the same edge: the set wins.
REQ-028 DONE_PULSE[c] and an accepted start on the same edge: the start wins; RUN stays/becomes 1.
REQ-029 DONE_PULSE while RUN=0: status and capture updated anyway; no error.
REQ-030 IRQ = OR over c of (IRQ_STAT[c] & IRQ_EN[c]), registered, one cycle after the contributing bit changes.

Reset
REQ-031 On RESETn low, asynchronously: all CTRL fields, RUN, ERR, DONE_SEEN, IRQ_STAT, IRQ_EN, CNT_LATCH, START_PULSE, PRDATA, PSLVERR and IRQ go to 0.
REQ-032 Reset asserted mid-run drops RUN; a DONE_PULSE arriving after release is handled per REQ-029.

Configuration
REQ-033 With macro GCD_REGBANK_DEBUG_EN defined, B+C reads DEBUG_IN[c*32 +: 32], read-only, no error.
REQ-034 Without GCD_REGBANK_DEBUG_EN, B+C is unmapped per REQ-023, and DEBUG_IN is unused.

Verification
REQ-035 Reset, read 0x00 with NUM_CH=2 -> PRDATA=0x5A5A0002, PSLVERR=0; read 0x30 -> PRDATA=0, PSLVERR=1.
REQ-036 Write 0x10=0x0000_0003 -> OPCODE[11:0]=1, START_PULSE[0] high for one cycle, STATUS(0x14) reads 0x1.
REQ-037 Channel 0 running, write 0x10=0x0000_0005 -> no pulse, OPCODE stays 1, PSLVERR=1, STATUS reads 0x3.
REQ-038 IRQ_EN=0x1, DONE_PULSE[0] with CYCLE_COUNT[0]=0x2A -> 0x18 reads 0x2A, IRQ_STAT=0x1, IRQ=1 next cycle; W1C 0x04=0x1 -> IRQ=0.
REQ-039 W1C of IRQ_STAT bit 1 coincident with DONE_PULSE[1] -> IRQ_STAT[1] remains 1.
REQ-040 Read 0x1C with DEBUG_IN[31:0]=0xDEADBEEF -> 0xDEADBEEF when GCD_REGBANK_DEBUG_EN is defined, else PRDATA=0 with PSLVERR=1.

Source files
------------

// File: rtl/gcd_apb_regbank_if.sv
// gcd_apb_regbank_if: APB3 slave bus bundle for the GCD register bank.
interface gcd_apb_regbank_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/gcd_apb_regbank.sv
// gcd_apb_regbank: APB register bank controlling NUM_CH GCD channels.
// Define GCD_REGBANK_DEBUG_EN to map the per-channel DEBUG_IN word at B+0xC.
module gcd_apb_regbank #(
  parameter int NUM_CH   = 2,
  parameter int OPCODE_W = 12,
  parameter int CNT_W    = 12
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  gcd_apb_regbank_if.slave             apb,
  output logic [NUM_CH-1:0]            START_PULSE,
  output logic [NUM_CH*OPCODE_W-1:0]   OPCODE,
  output logic [NUM_CH-1:0]            CONSTANT_TIME,
  output logic [NUM_CH-1:0]            DEBUG_MODE,
  input  logic [NUM_CH-1:0]            DONE_PULSE,
  input  logic [NUM_CH*CNT_W-1:0]      CYCLE_COUNT,
  input  logic [NUM_CH*32-1:0]         DEBUG_IN,
  output logic                         IRQ
);
  logic [NUM_CH*OPCODE_W-1:0] op_q, op_d;
  logic [NUM_CH-1:0] dm_q, dm_d, ct_q, ct_d, run_q, run_d, err_q, err_d, seen_q, seen_d;
  logic [NUM_CH-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, start_q, start_d;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [31:0] prdata_q, prdata_d, rdata;
  logic pslverr_q, pslverr_d, irq_q, irq_d;
  logic setup, wr, hit;
  logic [3:0] blk;
  logic [1:0] sel;
  logic [NUM_CH-1:0] cs, wctl, wst, rj;
  always_comb begin
    setup = apb.PSEL & ~apb.PENABLE;
    wr = setup & apb.PWRITE;
    blk = apb.PADDR[7:4];
    sel = apb.PADDR[3:2];
    hit = 1'b0;
    rdata = '0;
    op_d = op_q;
    dm_d = dm_q;
    ct_d = ct_q;
    irq_en_d = irq_en_q;
    irq_stat_d = irq_stat_q;
    if (blk == 4'd0) begin
      hit = sel != 2'd3;
      rdata = sel == 2'd0 ? (32'h5A5A_0000 | 32'(NUM_CH)) :
              sel == 2'd1 ? 32'(irq_stat_q) :
              sel == 2'd2 ? 32'(irq_en_q) : '0;
      if (wr && sel == 2'd1) irq_stat_d = irq_stat_q & ~apb.PWDATA[NUM_CH-1:0];
      if (wr && sel == 2'd2) irq_en_d = apb.PWDATA[NUM_CH-1:0];
    end
    // a completion in the same cycle as a W1C keeps the bit set
    irq_stat_d = irq_stat_d | DONE_PULSE;
    for (int c = 0; c < NUM_CH; c++) begin
      cs[c] = blk == 4'(c + 1);
      wctl[c] = wr & cs[c] & (sel == 2'd0);
      wst[c] = wr & cs[c] & (sel == 2'd1);
      start_d[c] = wctl[c] & apb.PWDATA[0] & ~run_q[c];
      rj[c] = wctl[c] & apb.PWDATA[0] & run_q[c];
      if (wctl[c] && !rj[c]) begin
        op_d[c*OPCODE_W +: OPCODE_W] = apb.PWDATA[OPCODE_W:1];
        dm_d[c] = apb.PWDATA[17];
        ct_d[c] = apb.PWDATA[18];
      end
      err_d[c] = (err_q[c] & ~(wst[c] & apb.PWDATA[1])) | rj[c];
      seen_d[c] = (seen_q[c] & ~(wst[c] & apb.PWDATA[2])) | DONE_PULSE[c];
      run_d[c] = start_q[c] | (run_q[c] & ~DONE_PULSE[c]);
      cnt_d[c] = DONE_PULSE[c] ? CYCLE_COUNT[c*CNT_W +: CNT_W] : cnt_q[c];
      if (cs[c]) begin
`ifdef GCD_REGBANK_DEBUG_EN
        hit = 1'b1;
`else
        hit = sel != 2'd3;
`endif
        rdata = sel == 2'd0 ? 32'({ct_q[c], dm_q[c], 17'(op_q[c*OPCODE_W +: OPCODE_W]) << 1}) :
                sel == 2'd1 ? 32'({seen_q[c], err_q[c], run_q[c]}) :
                sel == 2'd2 ? 32'(cnt_q[c]) :
`ifdef GCD_REGBANK_DEBUG_EN
                DEBUG_IN[c*32 +: 32];
`else
                '0;
`endif
      end
    end
    prdata_d = setup ? ((apb.PWRITE || !hit) ? '0 : rdata) : prdata_q;
    pslverr_d = setup ? (~hit | (|rj)) : pslverr_q;
    irq_d = |(irq_stat_q & irq_en_q);
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      op_q <= '0;
      dm_q <= '0;
      ct_q <= '0;
      run_q <= '0;
      err_q <= '0;
      seen_q <= '0;
      irq_stat_q <= '0;
      irq_en_q <= '0;
      start_q <= '0;
      cnt_q <= '{default: '0};
      prdata_q <= '0;
      pslverr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      op_q <= op_d;
      dm_q <= dm_d;
      ct_q <= ct_d;
      run_q <= run_d;
      err_q <= err_d;
      seen_q <= seen_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q <= irq_en_d;
      start_q <= start_d;
      cnt_q <= cnt_d;
      prdata_q <= prdata_d;
      pslverr_q <= pslverr_d;
      irq_q <= irq_d;
    end
  assign apb.PRDATA = prdata_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PREADY = 1'b1;
  assign START_PULSE = start_q;
  assign OPCODE = op_q;
  assign CONSTANT_TIME = ct_q;
  assign DEBUG_MODE = dm_q;
  assign IRQ = irq_q;
  logic unused_bits;
`ifdef GCD_REGBANK_DEBUG_EN
  assign unused_bits = ^{apb.PADDR[31:8], apb.PADDR[1:0], apb.PWDATA};
`else
  assign unused_bits = ^{apb.PADDR[31:8], apb.PADDR[1:0], apb.PWDATA, DEBUG_IN};
`endif
endmodule
